mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//   Unified instruction/data memory that answers the MIPS core's memory ports.
//   Returns instructions for instr_addr and serves data loads/stores driven by data_addr/data_rd_wr/data_out.
//   A boot loader fills memory through a valid/ready load port before the core runs.
//   Sits beside the core at top level; mem_ready releases the core's reset.
// PARAMETERS
//   DEPTH           1024          number of 32-bit words (power of two, >=4)
//   BASE            32'h0000_0000 byte address of word 0 (word-aligned)
//   CLEAR_ON_RESET  1             1: zero every word after reset; 0: skip CLEAR
// PORTS
//   clk         in   1        clock, all state on rising edge
//   reset       in   1        asynchronous, active-low reset
//   instr_addr  in   32       core fetch byte address
//   instr_data  out  32       fetched instruction (to core instr_in)
//   data_rd_wr  in   1        1 = read, 0 = write
//   data_addr   in   32       core data byte address
//   data_wdata  in   32       store data (from core data_out)
//   data_rdata  out  32       load data (to core data_in)
//   ld_valid    in   1        loader word valid
//   ld_ready    out  1        loader word accepted when valid&ready
//   ld_addr     in   $clog2(DEPTH)  loader word index
//   ld_data     in   32       loader word
//   ld_done     in   1        loader finished (sampled in LOAD only)
//   mem_ready   out  1        1 in RUN; core may operate
//   fault       out  1        sticky: bad core access seen since reset
//   fault_addr  out  32       byte address of first faulting access
//   wr_count    out  16       core stores committed, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (reset=0, async): state=CLEAR (LOAD if CLEAR_ON_RESET=0); clr_idx=0;
//     every output 0. Memory contents are undefined until CLEAR finishes.
//   FSM CLEAR -> LOAD -> RUN; RUN is left only by reset.
//     CLEAR: write 0 to word clr_idx, then clr_idx++; after word DEPTH-1 -> LOAD (DEPTH cycles).
//     LOAD: ld_ready=1. valid&ready writes mem[ld_addr]<=ld_data in that cycle.
//       ld_done=1 -> RUN next cycle. A word presented together with ld_done is still written.
//     RUN: mem_ready=1, ld_ready=0, ld_valid ignored.
//   Outside RUN, core ports are ignored: instr_data/data_rdata stay 0, no stores, no faults.
//   Index: idx = (addr - BASE) >> 2. The address is in range iff addr >= BASE and idx < DEPTH.
//   Fetch (RUN): registered, 1-cycle latency. instr_data <= mem[idx(instr_addr)] every cycle.
//     Out of range or addr[1:0]!=0: instr_data <= 32'h0 (NOP) and the access faults.
//   Data read (RUN, data_rd_wr=1): data_rdata <= mem[idx(data_addr)], 1-cycle latency.
//     A bad address returns 0 and faults.
//   Data write (RUN, data_rd_wr=0): mem[idx] <= data_wdata at the edge; data_rdata holds its value.
//     A bad address drops the store and faults. Each write cycle increments wr_count.
//     The core holds a store for several cycles, so repeated identical writes each count.
//   Same-edge fetch and store to the same word: instr_data returns the OLD word (read-before-write).
//   Fault: the first fault sets fault=1 and latches fault_addr. The data port has priority if both ports fault in one cycle.
//     Later faults do not update either output. Both clear only on reset.
//   Reset asserted mid-LOAD or mid-RUN: immediate return to reset values and a fresh CLEAR; no partial write completes.
// TESTING
//   CLEAR: DEPTH=16, release reset -> mem_ready=0 for 16 clear cycles + LOAD; all 16 words read back 0.
//   Load: ld words 0..3 = 32'h2401_0005.., ld_done -> mem_ready=1 next cycle.
//     instr_addr=BASE+4 -> instr_data=word1 one cycle later.
//   Store/load: write 32'hDEAD_BEEF @BASE+8 held 5 cycles -> wr_count=5.
//     Then read @BASE+8 -> data_rdata=32'hDEAD_BEEF after 1 cycle.
//   Collision: fetch and store 32'h1234_5678 to BASE+12 on the same edge -> instr_data=old word.
//     Next fetch returns 32'h1234_5678.
//   Faults: store @BASE+4*DEPTH, then read @BASE+2 -> store dropped, fault=1, fault_addr=BASE+4*DEPTH (not BASE+2).
//   Reset mid-LOAD after 2 words -> outputs 0, CLEAR reruns, loaded words read back 0.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Unified instruction/data memory for the MIPS core with a boot-loader port.
// Clears itself after reset, accepts loader words, then serves fetch/load/store.
module mips_mem_responder #(
   parameter int unsigned DEPTH          = 1024,
   parameter logic [31:0] BASE           = 32'h0000_0000,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              instr_addr,
   output logic [31:0]              instr_data,
   input  logic                     data_rd_wr,
   input  logic [31:0]              data_addr,
   input  logic [31:0]              data_wdata,
   output logic [31:0]              data_rdata,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [31:0]              ld_data,
   input  logic                     ld_done,
   output logic                     mem_ready,
   output logic                     fault,
   output logic [31:0]              fault_addr,
   output logic [15:0]              wr_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_LOAD,
      S_RUN
   } state_t;

   localparam state_t RST_ST = CLEAR_ON_RESET ? S_CLEAR : S_LOAD;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_clr_idx;
   logic [31:0]   r_mem [DEPTH];

   logic [31:0]   w_ioff;
   logic [31:0]   w_doff;
   logic          w_iok;
   logic          w_dok;
   logic [AW-1:0] w_iidx;
   logic [AW-1:0] w_didx;
   logic          w_run;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [31:0]   w_wdata;

   // In range: at/above BASE, word offset below DEPTH, and word aligned.
   assign w_ioff = instr_addr - BASE;
   assign w_doff = data_addr - BASE;
   assign w_iok  = (instr_addr >= BASE)
                && ({2'b00, w_ioff[31:2]} < 32'(DEPTH))
                && (w_ioff[1:0] == 2'b00);
   assign w_dok  = (data_addr >= BASE)
                && ({2'b00, w_doff[31:2]} < 32'(DEPTH))
                && (w_doff[1:0] == 2'b00);
   assign w_iidx = w_ioff[AW+1:2];
   assign w_didx = w_doff[AW+1:2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RST_ST;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_CLEAR: if (r_clr_idx == AW'(DEPTH - 1)) w_next = S_LOAD;
         S_LOAD:  if (ld_done) w_next = S_RUN;
         S_RUN:   w_next = S_RUN;
         default: w_next = RST_ST;
      endcase
   end

   always_comb begin
      w_run     = (r_state == S_RUN);
      mem_ready = w_run;
      ld_ready  = (r_state == S_LOAD) && reset;
   end

   // Single write port shared by clear, loader and core stores.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_clr_idx;
      w_wdata = 32'h0;
      unique case (r_state)
         S_CLEAR: w_we = 1'b1;
         S_LOAD: begin
            w_we    = ld_valid;
            w_waddr = ld_addr;
            w_wdata = ld_data;
         end
         S_RUN: begin
            w_we    = !data_rd_wr && w_dok;
            w_waddr = w_didx;
            w_wdata = data_wdata;
         end
         default: w_we = 1'b0;
      endcase
      w_we = w_we && reset;
   end

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clr_idx  <= '0;
         instr_data <= 32'h0;
         data_rdata <= 32'h0;
         fault      <= 1'b0;
         fault_addr <= 32'h0;
         wr_count   <= 16'h0;
      end else begin
         if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
         if (w_run) begin
            instr_data <= w_iok ? r_mem[w_iidx] : 32'h0;
            if (data_rd_wr) begin
               data_rdata <= w_dok ? r_mem[w_didx] : 32'h0;
            end else if (w_dok && wr_count != 16'hFFFF) begin
               wr_count <= wr_count + 16'd1;
            end
            // First fault wins; data port beats fetch on a tie.
            if (!fault && (!w_dok || !w_iok)) begin
               fault      <= 1'b1;
               fault_addr <= !w_dok ? data_addr : instr_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder with a word-array reference model.
// Expectations are queued per clock edge and checked by an independent monitor.
module tb_mips_mem_responder;

   localparam int          D = 16;
   localparam logic [31:0] B = 32'h0000_1000;

   logic          clk;
   logic          reset;
   logic [31:0]   instr_addr;
   logic [31:0]   instr_data;
   logic          data_rd_wr;
   logic [31:0]   data_addr;
   logic [31:0]   data_wdata;
   logic [31:0]   data_rdata;
   logic          ld_valid;
   logic          ld_ready;
   logic [3:0]    ld_addr;
   logic [31:0]   ld_data;
   logic          ld_done;
   logic          mem_ready;
   logic          fault;
   logic [31:0]   fault_addr;
   logic [15:0]   wr_count;

   mips_mem_responder #(
      .DEPTH(D),
      .BASE(B),
      .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .instr_addr(instr_addr),
      .instr_data(instr_data),
      .data_rd_wr(data_rd_wr),
      .data_addr(data_addr),
      .data_wdata(data_wdata),
      .data_rdata(data_rdata),
      .ld_valid(ld_valid),
      .ld_ready(ld_ready),
      .ld_addr(ld_addr),
      .ld_data(ld_data),
      .ld_done(ld_done),
      .mem_ready(mem_ready),
      .fault(fault),
      .fault_addr(fault_addr),
      .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rdata;
      logic [31:0] faddr;
      logic        fault;
      logic        ready;
      logic        ldr;
      logic [15:0] wcnt;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   logic [31:0] m_mem[D];
   int          m_clr;
   bit          m_load;
   bit          m_run;
   int          n_chk = 0;
   int          n_fail = 0;

   function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
      n_chk++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
      end
   endfunction

   function automatic bit good(logic [31:0] a);
      longint la = longint'(a);
      longint lb = longint'(B);
      return la >= lb && (la - lb) < 4 * D && a[1:0] == 2'b00;
   endfunction

   function automatic int idx(logic [31:0] a);
      return int'((a - B) >> 2);
   endfunction

   // Advance the model across one rising edge and queue the post-edge outputs.
   task automatic step();
      logic [31:0] ni;
      if (m_run) begin
         ni = good(instr_addr) ? m_mem[idx(instr_addr)] : 32'h0;
         if (data_rd_wr) begin
            e.rdata = good(data_addr) ? m_mem[idx(data_addr)] : 32'h0;
         end else if (good(data_addr)) begin
            m_mem[idx(data_addr)] = data_wdata;
            if (e.wcnt != 16'hFFFF) e.wcnt = e.wcnt + 16'd1;
         end
         if (!e.fault) begin
            if (!good(data_addr)) begin
               e.fault = 1'b1;
               e.faddr = data_addr;
            end else if (!good(instr_addr)) begin
               e.fault = 1'b1;
               e.faddr = instr_addr;
            end
         end
         e.instr = ni;
      end else if (m_load) begin
         if (ld_valid) m_mem[ld_addr] = ld_data;
         if (ld_done) begin
            m_load = 1'b0;
            m_run  = 1'b1;
         end
      end else begin
         m_clr--;
         if (m_clr == 0) begin
            m_load = 1'b1;
            for (int i = 0; i < D; i++) m_mem[i] = 32'h0;
         end
      end
      e.ready = m_run;
      e.ldr   = m_load;
      @(posedge clk);
      q.push_back(e);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("instr_data", instr_data, x.instr);
         chk("data_rdata", data_rdata, x.rdata);
         chk("fault", 32'(fault), 32'(x.fault));
         chk("fault_addr", fault_addr, x.faddr);
         chk("wr_count", 32'(wr_count), 32'(x.wcnt));
         chk("mem_ready", 32'(mem_ready), 32'(x.ready));
         chk("ld_ready", 32'(ld_ready), 32'(x.ldr));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset = 1'b0;
      #2;
      chk("rst instr_data", instr_data, 32'h0);
      chk("rst data_rdata", data_rdata, 32'h0);
      chk("rst fault", 32'(fault), 32'h0);
      chk("rst fault_addr", fault_addr, 32'h0);
      chk("rst wr_count", 32'(wr_count), 32'h0);
      chk("rst mem_ready", 32'(mem_ready), 32'h0);
      chk("rst ld_ready", 32'(ld_ready), 32'h0);
      m_clr  = D;
      m_load = 1'b0;
      m_run  = 1'b0;
      e      = '{default: '0};
      for (int i = 0; i < D; i++) m_mem[i] = 'x;
      #1;
      reset = 1'b1;
   endtask

   task automatic core(logic [31:0] ia, logic rw, logic [31:0] da, logic [31:0] wd);
      instr_addr = ia;
      data_rd_wr = rw;
      data_addr  = da;
      data_wdata = wd;
   endtask

   task automatic load_word(int a, logic [31:0] d, logic done);
      ld_valid = 1'b1;
      ld_addr  = 4'(a);
      ld_data  = d;
      ld_done  = done;
      step();
      ld_valid = 1'b0;
      ld_done  = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr(bit allow_bad);
      int s = allow_bad ? $urandom_range(0, 9) : 9;
      logic [31:0] a;
      case (s)
         0:       a = B - 32'd4;
         1:       a = B + 32'(4 * D);
         2:       a = B + 32'($urandom_range(0, 4 * D - 1)) | 32'd1;
         default: a = B + 32'(4 * $urandom_range(0, D - 1));
      endcase
      return a;
   endfunction

   task automatic readback(string n);
      for (int i = 0; i < D; i++) begin
         core(B + 32'(4 * i), 1'b1, B + 32'(4 * i), 32'h0);
         step();
      end
      chk(n, 32'(q.size()), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      ld_valid = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      ld_done = 1'b0;
      core(32'h0, 1'b1, 32'h0, 32'h0);

      // Clear, idle load cycle, load all words (last one with ld_done).
      do_reset();
      repeat (D) step();
      ld_addr = 4'd3;
      ld_data = 32'hFFFF_FFFF;
      step();
      for (int i = 0; i < D; i++)
         load_word(i, i < 4 ? 32'h2401_0005 + 32'(i) : $urandom, i == D - 1);

      core(B + 32'd4, 1'b1, B, 32'h0);
      step();
      core(B + 32'd4, 1'b0, B + 32'd8, 32'hDEAD_BEEF);
      repeat (5) step();
      core(B + 32'd4, 1'b1, B + 32'd8, 32'h0);
      step();
      core(B + 32'd12, 1'b0, B + 32'd12, 32'h1234_5678);
      step();
      core(B + 32'd12, 1'b1, B + 32'd12, 32'h0);
      step();
      readback("run readback");

      for (int n = 0; n < 400; n++) begin
         core(rnd_addr($urandom_range(0, 7) == 0), 1'($urandom),
              rnd_addr(1'b1), $urandom);
         ld_valid = 1'($urandom);
         ld_addr  = 4'($urandom);
         ld_data  = $urandom;
         ld_done  = 1'($urandom);
         step();
      end
      ld_valid = 1'b0;
      ld_done  = 1'b0;

      // Bad store then misaligned read: only the store is recorded.
      do_reset();
      core(B + 32'(4 * D), 1'b0, B + 32'(4 * D), 32'hAAAA_5555);
      repeat (D) step();
      ld_done = 1'b1;
      step();
      ld_done = 1'b0;
      core(B, 1'b0, B + 32'(4 * D), 32'hAAAA_5555);
      step();
      core(B, 1'b1, B + 32'd2, 32'h0);
      step();
      readback("fault readback");

      // Reset part-way through loading wipes the loaded words.
      do_reset();
      repeat (D) step();
      load_word(0, 32'hCAFE_0000, 1'b0);
      load_word(1, 32'hCAFE_0001, 1'b0);
      do_reset();
      repeat (D) step();
      ld_done = 1'b1;
      step();
      ld_done = 1'b0;
      readback("clear readback");

      repeat (2) @(negedge clk);
      #1;
      chk("queue drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
